// File: rtl/reaction_game_pkg.sv
// Shared encodings for the two-player reaction game controller:
// FSM state codes and the round-result / winner codes.
package reaction_game_pkg;

  localparam int CNT_W   = 16;
  localparam int SCORE_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_COUNT = 3'd2,
    ST_GO    = 3'd3,
    ST_HOLD  = 3'd4,
    ST_WIN   = 3'd5
  } state_t;

  // Shared by round_result and winner; TIE also covers a go-window timeout.
  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_TIE  = 2'b11
  } result_t;

endpackage

// File: rtl/reaction_game_ctrl_if.sv
// Player-side and display-side signals of the reaction game controller.
// The controller uses the slave view; the board/bench drives the master view.
interface reaction_game_ctrl_if;
  import reaction_game_pkg::*;

  logic                 tick;
  logic                 start;
  logic                 sw_p1;
  logic                 sw_p2;
  logic                 lock;
  logic [SCORE_W-1:0]   p1_score;
  logic [SCORE_W-1:0]   p2_score;
  logic [1:0]           round_result;
  logic                 p1_fault;
  logic                 p2_fault;
  logic                 game_over;
  logic [1:0]           winner;
  logic [2:0]           state;

  modport slave (
    input  tick, start, sw_p1, sw_p2,
    output lock, p1_score, p2_score, round_result, p1_fault, p2_fault,
           game_over, winner, state
  );

  modport master (
    output tick, start, sw_p1, sw_p2,
    input  lock, p1_score, p2_score, round_result, p1_fault, p2_fault,
           game_over, winner, state
  );

endinterface

// File: rtl/input_sync_edge.sv
// Two-flop synchroniser for an asynchronous button/switch, plus a one-clk
// rising-edge pulse taken from the synchronised level.
module input_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic last;

  // NOTE: sequential state uses non-blocking assignments so the three flops
  // shift as a pipeline; blocking here would collapse them into one flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      last <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      last <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~last;

endmodule

// File: rtl/reaction_game_ctrl.sv
// Round sequencer and arbiter for the two-player reaction game: random
// countdown, go window, first-flip arbitration, false starts, scores, match win.
module reaction_game_ctrl
  import reaction_game_pkg::*;
#(
  parameter int unsigned WIN_SCORE  = 5,
  parameter int unsigned MIN_DELAY  = 1000,
  parameter int unsigned RAND_BITS  = 11,
  parameter int unsigned GO_TIMEOUT = 3000,
  parameter int unsigned HOLD_TICKS = 1000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  reaction_game_ctrl_if.slave  bus
);

  if (MIN_DELAY + (32'd1 << RAND_BITS) - 1 >= 65536) begin : g_bad_delay
    $error("MIN_DELAY + 2**RAND_BITS - 1 does not fit the 16-bit countdown");
  end
  if (RAND_BITS < 1 || RAND_BITS > 15) begin : g_bad_rand_bits
    $error("RAND_BITS must be in 1..15");
  end
  if (WIN_SCORE < 1 || WIN_SCORE > 7) begin : g_bad_win_score
    $error("WIN_SCORE must be in 1..7");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  localparam logic [CNT_W-1:0]   MIN_DELAY_W  = CNT_W'(MIN_DELAY);
  localparam logic [CNT_W-1:0]   RAND_MASK    = CNT_W'((32'd1 << RAND_BITS) - 32'd1);
  localparam logic [CNT_W-1:0]   GO_TIMEOUT_W = CNT_W'(GO_TIMEOUT);
  localparam logic [CNT_W-1:0]   HOLD_TICKS_W = CNT_W'(HOLD_TICKS);
  localparam logic [SCORE_W-1:0] WIN_SCORE_W  = SCORE_W'(WIN_SCORE);

  logic start_level, start_rise;
  logic p1_level, p1_rise;
  logic p2_level, p2_rise;

  input_sync_edge u_sync_start (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (bus.start),
    .level    (start_level),
    .rise     (start_rise)
  );

  input_sync_edge u_sync_p1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (bus.sw_p1),
    .level    (p1_level),
    .rise     (p1_rise)
  );

  input_sync_edge u_sync_p2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (bus.sw_p2),
    .level    (p2_level),
    .rise     (p2_rise)
  );

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1; a nonzero seed never reaches 0.
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= LFSR_SEED;
    else          lfsr <= {lfsr[14:0], lfsr_fb};
  end

  state_t             state_q;
  logic [CNT_W-1:0]   cnt;
  logic               lock_q;
  logic [SCORE_W-1:0] p1_score_q;
  logic [SCORE_W-1:0] p2_score_q;
  result_t            result_q;
  logic               p1_fault_q;
  logic               p2_fault_q;
  logic               game_over_q;
  result_t            winner_q;

  // The last tick of a countdown is the one that sees cnt at 1 (or already 0).
  logic cnt_last;
  assign cnt_last = (cnt < CNT_W'(2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt         <= '0;
      lock_q      <= 1'b0;
      p1_score_q  <= '0;
      p2_score_q  <= '0;
      result_q    <= RES_NONE;
      p1_fault_q  <= 1'b0;
      p2_fault_q  <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= RES_NONE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            p1_score_q <= '0;
            p2_score_q <= '0;
            state_q    <= ST_ARM;
          end
        end

        ST_ARM: begin
          result_q   <= RES_NONE;
          p1_fault_q <= 1'b0;
          p2_fault_q <= 1'b0;
          if (!p1_level && !p2_level) begin
            cnt     <= MIN_DELAY_W + (lfsr & RAND_MASK);
            state_q <= ST_COUNT;
          end
        end

        ST_COUNT: begin
          if (p1_rise || p2_rise) begin
            p1_fault_q <= p1_rise;
            p2_fault_q <= p2_rise;
            if (p1_rise && p1_score_q != '0) p1_score_q <= p1_score_q - SCORE_W'(1);
            if (p2_rise && p2_score_q != '0) p2_score_q <= p2_score_q - SCORE_W'(1);
            result_q <= RES_NONE;
            lock_q   <= 1'b0;
            cnt      <= HOLD_TICKS_W;
            state_q  <= ST_HOLD;
          end else if (bus.tick) begin
            if (cnt_last) begin
              lock_q  <= 1'b1;
              cnt     <= GO_TIMEOUT_W;
              state_q <= ST_GO;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end

        ST_GO: begin
          if (p1_rise && p2_rise) begin
            result_q <= RES_TIE;
            lock_q   <= 1'b0;
            cnt      <= HOLD_TICKS_W;
            state_q  <= ST_HOLD;
          end else if (p1_rise) begin
            if (p1_score_q < WIN_SCORE_W) p1_score_q <= p1_score_q + SCORE_W'(1);
            result_q <= RES_P1;
            lock_q   <= 1'b0;
            cnt      <= HOLD_TICKS_W;
            state_q  <= ST_HOLD;
          end else if (p2_rise) begin
            if (p2_score_q < WIN_SCORE_W) p2_score_q <= p2_score_q + SCORE_W'(1);
            result_q <= RES_P2;
            lock_q   <= 1'b0;
            cnt      <= HOLD_TICKS_W;
            state_q  <= ST_HOLD;
          end else if (bus.tick) begin
            if (cnt_last) begin
              result_q <= RES_TIE;
              lock_q   <= 1'b0;
              cnt      <= HOLD_TICKS_W;
              state_q  <= ST_HOLD;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end

        ST_HOLD: begin
          if (bus.tick) begin
            if (cnt_last) begin
              if (p1_score_q == WIN_SCORE_W) begin
                game_over_q <= 1'b1;
                winner_q    <= RES_P1;
                state_q     <= ST_WIN;
              end else if (p2_score_q == WIN_SCORE_W) begin
                game_over_q <= 1'b1;
                winner_q    <= RES_P2;
                state_q     <= ST_WIN;
              end else begin
                state_q <= ST_ARM;
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end

        ST_WIN: begin
          lock_q <= 1'b0;
          if (start_rise) begin
            p1_score_q  <= '0;
            p2_score_q  <= '0;
            winner_q    <= RES_NONE;
            game_over_q <= 1'b0;
            state_q     <= ST_ARM;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.lock         = lock_q;
  assign bus.p1_score     = p1_score_q;
  assign bus.p2_score     = p2_score_q;
  assign bus.round_result = result_q;
  assign bus.p1_fault     = p1_fault_q;
  assign bus.p2_fault     = p2_fault_q;
  assign bus.game_over    = game_over_q;
  assign bus.winner       = winner_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed self-checking bench for reaction_game_ctrl with short timing
// parameters and a tick every 4 clk.
module tb_reaction_game_ctrl;

  localparam int S_IDLE  = 0;
  localparam int S_ARM   = 1;
  localparam int S_COUNT = 2;
  localparam int S_GO    = 3;
  localparam int S_HOLD  = 4;
  localparam int S_WIN   = 5;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  int   tick_div;

  reaction_game_ctrl_if bus ();

  reaction_game_ctrl #(
    .WIN_SCORE  (5),
    .MIN_DELAY  (5),
    .RAND_BITS  (1),
    .GO_TIMEOUT (6),
    .HOLD_TICKS (3),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tick_div = 0;
    bus.tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_div = (tick_div + 1) % 4;
      bus.tick = (tick_div == 0);
    end
  end

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic wait_state(input string tag, input int s, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(bus.state) == s) break;
    end
    check(tag, int'(bus.state), s);
  endtask

  task automatic wait_lock(input string tag, input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n++;
      if (bus.lock) break;
    end
    check(tag, int'(bus.lock), 1);
    check({tag, "_state"}, int'(bus.state), S_GO);
  endtask

  int n;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.sw_p1 = 1'b0;
    bus.sw_p2 = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_state", int'(bus.state), S_IDLE);
    check("rst_lock", int'(bus.lock), 0);
    check("rst_p1_score", int'(bus.p1_score), 0);
    check("rst_p2_score", int'(bus.p2_score), 0);
    check("rst_result", int'(bus.round_result), 0);
    check("rst_game_over", int'(bus.game_over), 0);
    check("rst_winner", int'(bus.winner), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Round 1: normal round, p1 wins; countdown is 5 or 6 ticks.
    bus.start = 1'b1;
    wait_state("start_to_arm", S_ARM, 4);
    bus.start = 1'b0;
    wait_state("arm_to_count", S_COUNT, 2);
    wait_lock("r1_lock", 60, n);
    check("r1_delay_in_range", int'(n >= 17 && n <= 24), 1);
    bus.sw_p1 = 1'b1;
    wait_state("r1_hold", S_HOLD, 4);
    check("r1_p1_score", int'(bus.p1_score), 1);
    check("r1_result", int'(bus.round_result), 1);
    check("r1_lock_low", int'(bus.lock), 0);
    bus.sw_p1 = 1'b0;

    // Round 2: p2 wins.
    wait_state("r2_count", S_COUNT, 40);
    wait_lock("r2_lock", 60, n);
    bus.sw_p2 = 1'b1;
    wait_state("r2_hold", S_HOLD, 4);
    check("r2_p2_score", int'(bus.p2_score), 1);
    check("r2_p1_score", int'(bus.p1_score), 1);
    check("r2_result", int'(bus.round_result), 2);
    bus.sw_p2 = 1'b0;

    // Round 3: p2 false start with score 1.
    wait_state("r3_count", S_COUNT, 40);
    bus.sw_p2 = 1'b1;
    wait_state("r3_hold", S_HOLD, 4);
    check("r3_p2_fault", int'(bus.p2_fault), 1);
    check("r3_p1_fault", int'(bus.p1_fault), 0);
    check("r3_p2_score", int'(bus.p2_score), 0);
    check("r3_p1_score", int'(bus.p1_score), 1);
    check("r3_result", int'(bus.round_result), 0);
    check("r3_lock", int'(bus.lock), 0);
    bus.sw_p2 = 1'b0;

    // Round 4: p2 false start with score already 0.
    wait_state("r4_count", S_COUNT, 40);
    check("r4_fault_cleared", int'(bus.p2_fault), 0);
    bus.sw_p2 = 1'b1;
    wait_state("r4_hold", S_HOLD, 4);
    check("r4_p2_fault", int'(bus.p2_fault), 1);
    check("r4_p2_score_sat", int'(bus.p2_score), 0);
    bus.sw_p2 = 1'b0;

    // Round 5: both flip in the same clk during go.
    wait_state("r5_count", S_COUNT, 40);
    wait_lock("r5_lock", 60, n);
    bus.sw_p1 = 1'b1;
    bus.sw_p2 = 1'b1;
    wait_state("r5_hold", S_HOLD, 4);
    check("r5_result_tie", int'(bus.round_result), 3);
    check("r5_p1_score", int'(bus.p1_score), 1);
    check("r5_p2_score", int'(bus.p2_score), 0);
    bus.sw_p1 = 1'b0;
    bus.sw_p2 = 1'b0;

    // Round 6: go window times out.
    wait_state("r6_count", S_COUNT, 40);
    wait_lock("r6_lock", 60, n);
    wait_state("r6_timeout_hold", S_HOLD, 32);
    check("r6_result_tie", int'(bus.round_result), 3);
    check("r6_lock", int'(bus.lock), 0);
    check("r6_p1_score", int'(bus.p1_score), 1);

    // ARM gate: switch edge in HOLD is ignored, held switch blocks ARM.
    bus.sw_p1 = 1'b1;
    repeat (4) @(negedge clk);
    check("hold_result_stable", int'(bus.round_result), 3);
    wait_state("gate_arm", S_ARM, 30);
    check("gate_p1_score", int'(bus.p1_score), 1);
    repeat (20) @(negedge clk);
    check("gate_stays_arm", int'(bus.state), S_ARM);
    check("gate_lock", int'(bus.lock), 0);
    bus.sw_p1 = 1'b0;
    wait_state("gate_release", S_COUNT, 4);

    // p1 wins four more rounds to reach 5.
    for (int k = 2; k <= 5; k++) begin
      wait_lock("win_lock", 60, n);
      bus.sw_p1 = 1'b1;
      wait_state("win_hold", S_HOLD, 4);
      check("win_p1_score", int'(bus.p1_score), k);
      bus.sw_p1 = 1'b0;
      if (k < 5) wait_state("win_count", S_COUNT, 40);
    end
    wait_state("match_win", S_WIN, 40);
    check("win_game_over", int'(bus.game_over), 1);
    check("win_winner", int'(bus.winner), 1);
    for (int k = 0; k < 3; k++) begin
      bus.sw_p1 = 1'b1;
      bus.sw_p2 = 1'b0;
      repeat (4) @(negedge clk);
      bus.sw_p1 = 1'b0;
      bus.sw_p2 = 1'b1;
      repeat (4) @(negedge clk);
    end
    bus.sw_p2 = 1'b0;
    check("win_lock_low", int'(bus.lock), 0);
    check("win_state_kept", int'(bus.state), S_WIN);
    check("win_score_kept", int'(bus.p1_score), 5);
    bus.start = 1'b1;
    wait_state("win_restart", S_ARM, 4);
    bus.start = 1'b0;
    check("restart_p1_score", int'(bus.p1_score), 0);
    check("restart_winner", int'(bus.winner), 0);
    check("restart_game_over", int'(bus.game_over), 0);

    // Reset in the middle of a countdown with a nonzero score.
    wait_lock("pre_rst_lock", 60, n);
    bus.sw_p1 = 1'b1;
    wait_state("pre_rst_hold", S_HOLD, 4);
    check("pre_rst_p1_score", int'(bus.p1_score), 1);
    bus.sw_p1 = 1'b0;
    wait_state("pre_rst_count", S_COUNT, 40);
    reset_n = 1'b0;
    #1;
    check("midrst_state", int'(bus.state), S_IDLE);
    check("midrst_lock", int'(bus.lock), 0);
    check("midrst_p1_score", int'(bus.p1_score), 0);
    check("midrst_result", int'(bus.round_result), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    wait_state("post_rst_arm", S_ARM, 4);
    bus.start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
